// File: rtl/spi_cmd_framer.sv
// Assembles one real-time command frame from the MCU byte stream, validates it,
// and commits all fields in parallel with a one-cycle SPI_WR strobe.
module spi_cmd_framer #(
  parameter int unsigned TIMEOUT_CLK = 4800,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter logic [7:0]  OPC_WRITE   = 8'h01
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic [47:0] FREQ,
  output logic [47:0] FREQ_STEP,
  output logic [31:0] FREQ_RATE,
  output logic [63:0] TIME_START,
  output logic [15:0] N_impulse,
  output logic [1:0]  TYPE_impulse,
  output logic [31:0] Interval_Ti,
  output logic [31:0] Interval_Tp,
  output logic [31:0] Tblank1,
  output logic [31:0] Tblank2,
  output logic        SPI_WR,
  output logic        CMD_ERR,
  output logic [7:0]  ERR_CNT,
  output logic        BUSY
);

  localparam int unsigned TW        = $clog2(TIMEOUT_CLK + 1);
  localparam int unsigned PAY_BYTES = 43;
  localparam int unsigned SH_W      = PAY_BYTES * 8;

  typedef enum logic [2:0] {S_HDR, S_OPC, S_PAY, S_CSUM, S_COMMIT} state_t;

  state_t            state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [7:0]        acc_q, acc_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [SH_W-1:0]   shadow_q, shadow_d;
  logic [47:0]       freq_q, freq_d, step_q, step_d;
  logic [31:0]       rate_q, rate_d;
  logic [63:0]       tstart_q, tstart_d;
  logic [15:0]       nimp_q, nimp_d;
  logic [1:0]        typ_q, typ_d;
  logic [31:0]       ti_q, ti_d, tp_q, tp_d, tb1_q, tb1_d, tb2_q, tb2_d;
  logic              spi_wr_q, spi_wr_d, cmd_err_q, cmd_err_d, busy_q, busy_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              reject_c;

  // Next-state and output computation
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    tmo_d     = '0;
    shadow_d  = shadow_q;
    freq_d    = freq_q;
    step_d    = step_q;
    rate_d    = rate_q;
    tstart_d  = tstart_q;
    nimp_d    = nimp_q;
    typ_d     = typ_q;
    ti_d      = ti_q;
    tp_d      = tp_q;
    tb1_d     = tb1_q;
    tb2_d     = tb2_q;
    spi_wr_d  = 1'b0;
    cmd_err_d = 1'b0;
    err_cnt_d = err_cnt_q;
    reject_c  = 1'b0;

    // Inter-byte timeout; a byte arriving on the expiry cycle takes priority
    if (state_q == S_OPC || state_q == S_PAY || state_q == S_CSUM) begin
      if (RX_VALID)                             tmo_d = '0;
      else if (tmo_q == TW'(TIMEOUT_CLK - 1))   reject_c = 1'b1;
      else                                      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      S_HDR: begin
        if (RX_VALID && RX_DATA == HDR_BYTE) state_d = S_OPC;
      end
      S_OPC: begin
        if (RX_VALID) begin
          if (RX_DATA == OPC_WRITE) begin
            state_d = S_PAY;
            acc_d   = RX_DATA;
            idx_d   = '0;
          end else begin
            reject_c = 1'b1;
          end
        end
      end
      S_PAY: begin
        if (RX_VALID) begin
          shadow_d = {shadow_q[SH_W-9:0], RX_DATA};
          acc_d    = acc_q + RX_DATA;
          idx_d    = idx_q + 6'd1;
          if (idx_q == 6'(PAY_BYTES - 1)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (RX_VALID) begin
          if (RX_DATA == acc_q) state_d = S_COMMIT;
          else                  reject_c = 1'b1;
        end
      end
      S_COMMIT: begin
        spi_wr_d = 1'b1;
        freq_d   = shadow_q[343:296];
        step_d   = shadow_q[295:248];
        rate_d   = shadow_q[247:216];
        tstart_d = shadow_q[215:152];
        nimp_d   = shadow_q[151:136];
        typ_d    = shadow_q[129:128];
        ti_d     = shadow_q[127:96];
        tp_d     = shadow_q[95:64];
        tb1_d    = shadow_q[63:32];
        tb2_d    = shadow_q[31:0];
        // The commit cycle doubles as a header-hunt cycle
        state_d  = (RX_VALID && RX_DATA == HDR_BYTE) ? S_OPC : S_HDR;
      end
      default: state_d = S_HDR;
    endcase

    if (reject_c) begin
      state_d   = S_HDR;
      tmo_d     = '0;
      cmd_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    busy_d = (state_d != S_HDR);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_HDR;
      idx_q     <= '0;
      acc_q     <= '0;
      tmo_q     <= '0;
      shadow_q  <= '0;
      freq_q    <= '0;
      step_q    <= '0;
      rate_q    <= '0;
      tstart_q  <= '0;
      nimp_q    <= '0;
      typ_q     <= '0;
      ti_q      <= '0;
      tp_q      <= '0;
      tb1_q     <= '0;
      tb2_q     <= '0;
      spi_wr_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      tmo_q     <= tmo_d;
      shadow_q  <= shadow_d;
      freq_q    <= freq_d;
      step_q    <= step_d;
      rate_q    <= rate_d;
      tstart_q  <= tstart_d;
      nimp_q    <= nimp_d;
      typ_q     <= typ_d;
      ti_q      <= ti_d;
      tp_q      <= tp_d;
      tb1_q     <= tb1_d;
      tb2_q     <= tb2_d;
      spi_wr_q  <= spi_wr_d;
      cmd_err_q <= cmd_err_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign FREQ         = freq_q;
  assign FREQ_STEP    = step_q;
  assign FREQ_RATE    = rate_q;
  assign TIME_START   = tstart_q;
  assign N_impulse    = nimp_q;
  assign TYPE_impulse = typ_q;
  assign Interval_Ti  = ti_q;
  assign Interval_Tp  = tp_q;
  assign Tblank1      = tb1_q;
  assign Tblank2      = tb2_q;
  assign SPI_WR       = spi_wr_q;
  assign CMD_ERR      = cmd_err_q;
  assign ERR_CNT      = err_cnt_q;
  assign BUSY         = busy_q;

endmodule

// File: tb/tb_spi_cmd_framer.sv
// Self-checking bench for spi_cmd_framer: vector table, hand-written corner
// sequences and randomized frames against a field-level reference model.
module tb_spi_cmd_framer;

  typedef struct {
    logic [47:0] freq;
    logic [47:0] step;
    logic [31:0] rate;
    logic [63:0] ts;
    logic [15:0] n;
    logic [1:0]  typ;
    logic [31:0] ti, tp, tb1, tb2;
  } fields_t;

  typedef struct {
    fields_t f;
    int      corrupt;   // 0 good, 1 bad checksum, 2 bad opcode
    int      exp_wr;
    int      exp_err;
  } vector_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic [47:0] FREQ, FREQ_STEP;
  logic [31:0] FREQ_RATE;
  logic [63:0] TIME_START;
  logic [15:0] N_impulse;
  logic [1:0]  TYPE_impulse;
  logic [31:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
  logic        SPI_WR, CMD_ERR, BUSY;
  logic [7:0]  ERR_CNT;

  spi_cmd_framer dut (
    .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE),
    .TIME_START(TIME_START), .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse),
    .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp),
    .Tblank1(Tblank1), .Tblank2(Tblank2),
    .SPI_WR(SPI_WR), .CMD_ERR(CMD_ERR), .ERR_CNT(ERR_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int wr_pulses = 0;
  int err_pulses = 0;
  int wr_cyc_last = 0;
  int wr_cyc_prev = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor
  always @(negedge CLK) begin
    if (SPI_WR === 1'b1) begin
      wr_pulses   = wr_pulses + 1;
      wr_cyc_prev = wr_cyc_last;
      wr_cyc_last = cyc;
    end
    if (CMD_ERR === 1'b1) err_pulses = err_pulses + 1;
  end

  // Reference model state
  fields_t exp_f;
  int      exp_errcnt = 0;
  int      exp_wr = 0;
  int      exp_errp = 0;
  logic [7:0] fb [0:45];
  vector_t vec [0:4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic put(input logic [63:0] v, input int nb, inout int p);
    for (int k = nb - 1; k >= 0; k--) begin
      fb[p] = v[8*k +: 8];
      p++;
    end
  endtask

  // Frame image built straight from the field list and the checksum rule
  task automatic build(input fields_t f, input int corrupt);
    int p;
    int s;
    fb[0] = 8'hA5;
    fb[1] = (corrupt == 2) ? 8'h02 : 8'h01;
    p = 2;
    put(64'(f.freq), 6, p);
    put(64'(f.step), 6, p);
    put(64'(f.rate), 4, p);
    put(f.ts, 8, p);
    put(64'(f.n), 2, p);
    put(64'({6'($urandom), f.typ}), 1, p);
    put(64'(f.ti), 4, p);
    put(64'(f.tp), 4, p);
    put(64'(f.tb1), 4, p);
    put(64'(f.tb2), 4, p);
    s = 0;
    for (int i = 1; i < 45; i++) s += int'(fb[i]);
    if (corrupt == 1) s += 1;
    fb[45] = 8'(s);
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_VALID = 1'b1;
    RX_DATA  = b;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    RX_VALID = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_range(input int first, input int last, input int gapmax);
    for (int i = first; i <= last; i++) begin
      send_byte(fb[i]);
      if (gapmax > 0) idle($urandom_range(gapmax, 0));
    end
  endtask

  task automatic model_frame(input fields_t f, input int corrupt);
    if (corrupt == 0) begin
      exp_f = f;
      exp_wr++;
    end else begin
      exp_errp++;
      if (exp_errcnt < 255) exp_errcnt++;
    end
  endtask

  task automatic check_fields(input string tag);
    check({tag, ".FREQ"},  64'(FREQ),         64'(exp_f.freq));
    check({tag, ".STEP"},  64'(FREQ_STEP),    64'(exp_f.step));
    check({tag, ".RATE"},  64'(FREQ_RATE),    64'(exp_f.rate));
    check({tag, ".TSTART"}, TIME_START,       exp_f.ts);
    check({tag, ".N"},     64'(N_impulse),    64'(exp_f.n));
    check({tag, ".TYPE"},  64'(TYPE_impulse), 64'(exp_f.typ));
    check({tag, ".TI"},    64'(Interval_Ti),  64'(exp_f.ti));
    check({tag, ".TP"},    64'(Interval_Tp),  64'(exp_f.tp));
    check({tag, ".TB1"},   64'(Tblank1),      64'(exp_f.tb1));
    check({tag, ".TB2"},   64'(Tblank2),      64'(exp_f.tb2));
  endtask

  task automatic check_all(input string tag);
    check_fields(tag);
    check({tag, ".wr_pulses"},  64'(wr_pulses),  64'(exp_wr));
    check({tag, ".err_pulses"}, 64'(err_pulses), 64'(exp_errp));
    check({tag, ".ERR_CNT"},    64'(ERR_CNT),    64'(exp_errcnt));
    check({tag, ".BUSY"},       64'(BUSY),       64'd0);
  endtask

  task automatic apply_frame(input fields_t f, input int corrupt, input int gapmax);
    build(f, corrupt);
    send_range(0, (corrupt == 2) ? 1 : 45, gapmax);
    idle(3);
    model_frame(f, corrupt);
  endtask

  function automatic fields_t rand_fields();
    fields_t f;
    f.freq = {16'($urandom), 32'($urandom)};
    f.step = {16'($urandom), 32'($urandom)};
    f.rate = $urandom;
    f.ts   = {32'($urandom), 32'($urandom)};
    f.n    = 16'($urandom);
    f.typ  = 2'($urandom);
    f.ti   = $urandom;
    f.tp   = $urandom;
    f.tb1  = $urandom;
    f.tb2  = $urandom;
    return f;
  endfunction

  initial begin
    fields_t t1, t2, ones, fr;
    int w0, e0, bad, corrupt;

    t1 = '{48'h001000000000, 48'h000000100000, 32'h100, 64'h12C0, 16'h2, 2'h1,
           32'h1800, 32'h1800, 32'h180, 32'h180};
    t2 = '{48'h123456789ABC, 48'hFEDCBA987654, 32'hA5A5A5A5, 64'h0011223344556677,
           16'hBEEF, 2'h2, 32'h1, 32'h2, 32'h3, 32'h4};
    ones = '{'1, '1, '1, '1, '1, 2'h3, '1, '1, '1, '1};
    exp_f = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0};
    vec[0] = '{t1, 0, 1, 0};
    vec[1] = '{t1, 1, 0, 1};
    vec[2] = '{t2, 2, 0, 1};
    vec[3] = '{t2, 0, 1, 0};
    vec[4] = '{ones, 0, 1, 0};

    // Reset state
    repeat (2) @(negedge CLK);
    check_all("reset");
    check("reset.SPI_WR",  64'(SPI_WR),  64'd0);
    check("reset.CMD_ERR", 64'(CMD_ERR), 64'd0);
    RESET = 1'b0;
    idle(2);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      w0 = wr_pulses;
      e0 = err_pulses;
      apply_frame(vec[v].f, vec[v].corrupt, 0);
      check($sformatf("vec%0d.wr_delta", v),  64'(wr_pulses - w0),  64'(vec[v].exp_wr));
      check($sformatf("vec%0d.err_delta", v), 64'(err_pulses - e0), 64'(vec[v].exp_err));
      check_all($sformatf("vec%0d", v));
    end

    // Strobe latency: SPI_WR one clock after the checksum byte, one cycle wide
    build(t1, 0);
    send_range(0, 45, 0);
    RX_VALID = 1'b0;
    check("lat.before", 64'(SPI_WR), 64'd0);
    @(negedge CLK);
    check("lat.strobe", 64'(SPI_WR), 64'd1);
    model_frame(t1, 0);
    check_fields("lat");
    @(negedge CLK);
    check("lat.after", 64'(SPI_WR), 64'd0);
    idle(2);

    // Bad opcode followed by 43 non-header bytes: all ignored, BUSY stays low
    build(t2, 2);
    send_range(0, 1, 0);
    model_frame(t2, 2);
    bad = 0;
    for (int i = 0; i < 43; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      send_byte(b);
      if (BUSY !== 1'b0) bad++;
    end
    idle(3);
    check("opc.busy_violations", 64'(bad), 64'd0);
    check_all("opc");

    // Timeout: 4800 idle clocks after payload byte 20
    build(t2, 0);
    send_range(0, 0, 0);
    check("tmo.busy_hdr", 64'(BUSY), 64'd1);
    send_range(1, 22, 0);
    e0 = err_pulses;
    idle(4799);
    check("tmo.no_err_4799", 64'(err_pulses - e0), 64'd0);
    idle(2);
    check("tmo.err_4800", 64'(err_pulses - e0), 64'd1);
    exp_errp++;
    if (exp_errcnt < 255) exp_errcnt++;
    idle(2);
    check_all("tmo");
    apply_frame(t2, 0, 0);
    check_all("tmo.recover");

    // A 4799-clock stall is tolerated
    fr = rand_fields();
    build(fr, 0);
    send_range(0, 22, 0);
    idle(4799);
    send_range(23, 45, 0);
    idle(3);
    model_frame(fr, 0);
    check_all("stall4799");

    // Back-to-back frames with RX_VALID held high
    build(t1, 0);
    send_range(0, 45, 0);
    build(t2, 0);
    send_range(0, 45, 0);
    idle(3);
    model_frame(t1, 0);
    model_frame(t2, 0);
    check("b2b.spacing", 64'(wr_cyc_last - wr_cyc_prev), 64'd46);
    check_all("b2b");

    // Randomized frames with random gaps and random corruption
    for (int r = 0; r < 30; r++) begin
      fr = rand_fields();
      corrupt = $urandom_range(2, 0);
      apply_frame(fr, corrupt, 3);
      check_all($sformatf("rnd%0d", r));
    end

    // Asynchronous reset mid-payload
    build(rand_fields(), 0);
    send_range(0, 20, 0);
    RX_VALID = 1'b0;
    #2 RESET = 1'b1;
    #1;
    exp_f = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0};
    exp_errcnt = 0;
    check_fields("rst");
    check("rst.BUSY",    64'(BUSY),    64'd0);
    check("rst.ERR_CNT", 64'(ERR_CNT), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    idle(3);
    check("rst.no_err", 64'(err_pulses), 64'(exp_errp));
    apply_frame(t1, 0, 1);
    check_all("rst.recover");

    // Error counter saturation
    for (int i = 0; i < 256; i++) apply_frame(t1, 2, 0);
    check_all("sat256");
    apply_frame(t1, 1, 0);
    check_all("sat257");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
